// File: rtl/perf_counter_drain.sv
// Performance counter bank with atomic snapshot, drained one counter per
// valid/ready handshake over a shared reporting channel.
module perf_counter_drain #(
   parameter int NUM_EVENTS = 8,
   parameter int CNT_WIDTH  = 32,
   parameter int IDX_WIDTH  = $clog2(NUM_EVENTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  count_en,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  snap_req,
   input  logic                  clear_on_snap,
   output logic                  snap_busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_WIDTH-1:0]  out_idx,
   output logic [CNT_WIDTH-1:0]  out_value,
   output logic                  out_sat
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_EVENTS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt    [NUM_EVENTS];
   logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
   logic [NUM_EVENTS-1:0] sat;
   logic [NUM_EVENTS-1:0] shadow_sat;
   logic                 snap_take;
   logic [IDX_WIDTH-1:0] nxt_idx;

   assign snap_take = (state == IDLE) && snap_req;
   assign nxt_idx   = out_idx + 1'b1;

   // Live counters: a clearing snapshot moves the snap-cycle event into the new interval.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_EVENTS; i++) cnt[i] <= '0;
         sat <= '0;
      end else begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            if (snap_take && clear_on_snap) begin
               cnt[i] <= (count_en && event_i[i]) ? CNT_WIDTH'(1) : '0;
               sat[i] <= 1'b0;
            end else if (count_en && event_i[i]) begin
               if (&cnt[i]) sat[i] <= 1'b1;
               else         cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Snapshot/drain FSM; record outputs are registered so they hold under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= '0;
         shadow_sat <= '0;
         snap_busy  <= 1'b0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_value  <= '0;
         out_sat    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= cnt[i];
                  shadow_sat <= sat;
                  state      <= DRAIN;
                  snap_busy  <= 1'b1;
                  out_valid  <= 1'b1;
                  out_idx    <= '0;
                  out_value  <= cnt[0];
                  out_sat    <= sat[0];
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_idx == LAST_IDX) begin
                     state     <= IDLE;
                     snap_busy <= 1'b0;
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                     out_value <= '0;
                     out_sat   <= 1'b0;
                  end else begin
                     out_idx   <= nxt_idx;
                     out_value <= shadow[nxt_idx];
                     out_sat   <= shadow_sat[nxt_idx];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
